// File: rtl/rob_multi_commit.sv
`default_nettype none
// ============================================================================
// Module   : rob_multi_commit
// Purpose  : In-order reorder buffer with 2**IDX_W entries and a count-based
//            full flag, so every slot is usable. It accepts WB_PORTS
//            independent writeback channels plus a store-operand port, and
//            retires the head entry each cycle. It drives the register file,
//            store release, branch-predictor update and global redirect.
// Ports    : clk, rst (sync, active high), rdy (global enable), flush
//            alloc_*   : allocation at the tail (id = rob_tail_id)
//            wb_*      : packed writeback channels, channel k at [k*W +: W]
//            st_*      : store address/data resolution
//            q1_*/q2_* : combinational operand query (no writeback bypass)
//            rob_full/rob_empty/rob_count/rob_head_id/rob_tail_id : status
//            rf0_*/rf1_*, rob_store_*, rob_flush/rob_correct_pc, rob_bp_* :
//            registered single-cycle commit outputs
// Config   : ROB_DUAL_COMMIT_EN - when defined, a second REG entry may retire
//            in the same cycle as an older REG entry (rf1 port). When
//            undefined, rf1_en stays 0 and at most one entry retires.
// Revision : 1.0 - initial release
// ============================================================================
module rob_multi_commit #(
    parameter int IDX_W    = 3,
    parameter int XLEN     = 32,
    parameter int LSB_W    = 3,
    parameter int WB_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       alloc_valid,
    input  logic [1:0]                 alloc_kind,
    input  logic [4:0]                 alloc_rd,
    input  logic [XLEN-1:0]            alloc_val,
    input  logic                       alloc_ready,
    input  logic                       alloc_pred,
    input  logic [XLEN-1:0]            alloc_addr,
    input  logic [XLEN-1:0]            alloc_inst_addr,
    input  logic                       alloc_c,
    input  logic [LSB_W-1:0]           alloc_lsb_id,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]  wb_id,
    input  logic [WB_PORTS*XLEN-1:0]   wb_val,
    input  logic                       st_valid,
    input  logic [IDX_W-1:0]           st_id,
    input  logic [XLEN-1:0]            st_addr,
    input  logic [XLEN-1:0]            st_data,
    input  logic [IDX_W-1:0]           q1_id,
    input  logic [IDX_W-1:0]           q2_id,
    output logic                       q1_ready,
    output logic [XLEN-1:0]            q1_val,
    output logic                       q2_ready,
    output logic [XLEN-1:0]            q2_val,
    output logic                       rob_full,
    output logic                       rob_empty,
    output logic [IDX_W:0]             rob_count,
    output logic [IDX_W-1:0]           rob_head_id,
    output logic [IDX_W-1:0]           rob_tail_id,
    output logic                       rf0_en,
    output logic [4:0]                 rf0_rd,
    output logic [XLEN-1:0]            rf0_val,
    output logic                       rf1_en,
    output logic [4:0]                 rf1_rd,
    output logic [XLEN-1:0]            rf1_val,
    output logic                       rob_store_en,
    output logic [LSB_W-1:0]           rob_store_lsb_id,
    output logic                       rob_flush,
    output logic [XLEN-1:0]            rob_correct_pc,
    output logic                       rob_bp_en,
    output logic [XLEN-1:0]            rob_bp_inst_addr,
    output logic                       rob_bp_jump,
    output logic                       rob_bp_correct
);

    localparam int         C_DEPTH       = 1 << IDX_W;
    localparam logic [1:0] C_KIND_REG    = 2'd0;
    localparam logic [1:0] C_KIND_STORE  = 2'd1;
    localparam logic [1:0] C_KIND_BRANCH = 2'd2;
    localparam logic [1:0] C_KIND_JALR   = 2'd3;

    // Entry storage. Only the ready bits are reset; the payload is always
    // rewritten at allocation before it can be observed as live.
    logic [1:0]         r_kind [C_DEPTH];
    logic [4:0]         r_rd   [C_DEPTH];
    logic [XLEN-1:0]    r_val  [C_DEPTH];
    logic [XLEN-1:0]    r_addr [C_DEPTH];
    logic [XLEN-1:0]    r_pc   [C_DEPTH];
    logic [LSB_W-1:0]   r_lsb  [C_DEPTH];
    logic [C_DEPTH-1:0] r_ready;
    logic [C_DEPTH-1:0] r_pred;
    logic [C_DEPTH-1:0] r_c;

    logic [IDX_W-1:0]   r_head;
    logic [IDX_W-1:0]   r_tail;
    logic [IDX_W:0]     r_count;

    logic [C_DEPTH-1:0] w_live;
    logic               w_alloc;
    logic               w_commit0;
    logic               w_commit1;
    logic [IDX_W:0]     w_n_commit;
    logic               w_taken;

    assign rob_full    = (r_count == (IDX_W+1)'(C_DEPTH));
    assign rob_empty   = (r_count == '0);
    assign rob_count   = r_count;
    assign rob_head_id = r_head;
    assign rob_tail_id = r_tail;

    assign q1_ready = r_ready[q1_id];
    assign q1_val   = r_val[q1_id];
    assign q2_ready = r_ready[q2_id];
    assign q2_val   = r_val[q2_id];

    // An id is live when its distance from head is below the count; this
    // also covers the full case where head == tail.
    always_comb begin
        w_live = '0;
        for (int i = 0; i < C_DEPTH; i++) begin
            w_live[i] = ({1'b0, IDX_W'(IDX_W'(i) - r_head)} < r_count);
        end
    end

    assign w_alloc   = alloc_valid && !rob_full;
    assign w_commit0 = (r_count != '0) && r_ready[r_head];
    assign w_taken   = r_val[r_head][0];

`ifdef ROB_DUAL_COMMIT_EN
    logic [IDX_W-1:0] w_head1;
    assign w_head1   = r_head + IDX_W'(1);
    // The younger slot only retires alongside an older REG commit, so no
    // redirect or store release can be skipped by it.
    assign w_commit1 = w_commit0
                    && (r_count > (IDX_W+1)'(1))
                    && r_ready[w_head1]
                    && (r_kind[r_head] == C_KIND_REG)
                    && (r_kind[w_head1] == C_KIND_REG);
`else
    assign w_commit1 = 1'b0;
`endif

    assign w_n_commit = (IDX_W+1)'(w_commit0) + (IDX_W+1)'(w_commit1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_ready          <= '0;
            rf0_en           <= 1'b0;
            rf0_rd           <= '0;
            rf0_val          <= '0;
            rf1_en           <= 1'b0;
            rf1_rd           <= '0;
            rf1_val          <= '0;
            rob_store_en     <= 1'b0;
            rob_store_lsb_id <= '0;
            rob_flush        <= 1'b0;
            rob_correct_pc   <= '0;
            rob_bp_en        <= 1'b0;
            rob_bp_inst_addr <= '0;
            rob_bp_jump      <= 1'b0;
            rob_bp_correct   <= 1'b0;
        end else if (rdy) begin
            // Commit strobes are single-cycle pulses.
            rf0_en       <= 1'b0;
            rf1_en       <= 1'b0;
            rob_store_en <= 1'b0;
            rob_flush    <= 1'b0;
            rob_bp_en    <= 1'b0;

            if (flush) begin
                r_tail  <= r_head;
                r_count <= '0;
            end else begin
                // Later channels are written last, so the highest index wins
                // when two channels target the same id.
                for (int k = 0; k < WB_PORTS; k++) begin
                    if (wb_valid[k] && w_live[wb_id[k*IDX_W +: IDX_W]]) begin
                        r_ready[wb_id[k*IDX_W +: IDX_W]] <= 1'b1;
                        if (r_kind[wb_id[k*IDX_W +: IDX_W]] == C_KIND_JALR) begin
                            r_addr[wb_id[k*IDX_W +: IDX_W]] <= wb_val[k*XLEN +: XLEN];
                        end else begin
                            r_val[wb_id[k*IDX_W +: IDX_W]] <= wb_val[k*XLEN +: XLEN];
                        end
                    end
                end

                if (st_valid && w_live[st_id] && (r_kind[st_id] == C_KIND_STORE)) begin
                    r_addr[st_id]  <= st_addr;
                    r_val[st_id]   <= st_data;
                    r_ready[st_id] <= 1'b1;
                end

                // The tail slot is never live while not full, so allocation
                // cannot collide with a writeback in the same cycle.
                if (w_alloc) begin
                    r_kind[r_tail]  <= alloc_kind;
                    r_rd[r_tail]    <= alloc_rd;
                    r_val[r_tail]   <= alloc_val;
                    r_ready[r_tail] <= alloc_ready;
                    r_pred[r_tail]  <= alloc_pred;
                    r_addr[r_tail]  <= alloc_addr;
                    r_pc[r_tail]    <= alloc_inst_addr;
                    r_c[r_tail]     <= alloc_c;
                    r_lsb[r_tail]   <= alloc_lsb_id;
                    r_tail          <= r_tail + IDX_W'(1);
                end

                if (w_commit0) begin
                    case (r_kind[r_head])
                        C_KIND_REG: begin
                            rf0_en  <= 1'b1;
                            rf0_rd  <= r_rd[r_head];
                            rf0_val <= r_val[r_head];
                        end
                        C_KIND_STORE: begin
                            rob_store_en     <= 1'b1;
                            rob_store_lsb_id <= r_lsb[r_head];
                        end
                        C_KIND_BRANCH: begin
                            rob_bp_en        <= 1'b1;
                            rob_bp_inst_addr <= r_pc[r_head];
                            rob_bp_jump      <= w_taken;
                            rob_bp_correct   <= (r_pred[r_head] == w_taken);
                            if (r_pred[r_head] != w_taken) begin
                                rob_flush      <= 1'b1;
                                rob_correct_pc <= w_taken ? r_addr[r_head]
                                                : r_pc[r_head] + (r_c[r_head] ? XLEN'(2) : XLEN'(4));
                            end
                        end
                        default: begin
                            // JALR: link value is written at allocation,
                            // target arrives through writeback.
                            rf0_en         <= 1'b1;
                            rf0_rd         <= r_rd[r_head];
                            rf0_val        <= r_val[r_head];
                            rob_flush      <= 1'b1;
                            rob_correct_pc <= r_addr[r_head];
                        end
                    endcase
                end

`ifdef ROB_DUAL_COMMIT_EN
                if (w_commit1) begin
                    rf1_en  <= 1'b1;
                    rf1_rd  <= r_rd[w_head1];
                    rf1_val <= r_val[w_head1];
                end
`endif

                r_head  <= r_head + w_n_commit[IDX_W-1:0];
                r_count <= r_count + (IDX_W+1)'(w_alloc) - w_n_commit;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_multi_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_multi_commit
// Purpose  : Self-checking bench for rob_multi_commit. A queue-based model of
//            the live entries predicts every registered output; directed
//            sequences add literal expectations, followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_multi_commit;

    localparam int IDX_W    = 3;
    localparam int XLEN     = 32;
    localparam int LSB_W    = 3;
    localparam int WB_PORTS = 2;
    localparam int DEPTH    = 8;
`ifdef ROB_DUAL_COMMIT_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst, rdy, flush;
    logic                      alloc_valid, alloc_ready, alloc_pred, alloc_c;
    logic [1:0]                alloc_kind;
    logic [4:0]                alloc_rd;
    logic [XLEN-1:0]           alloc_val, alloc_addr, alloc_inst_addr;
    logic [LSB_W-1:0]          alloc_lsb_id;
    logic [WB_PORTS-1:0]       wb_valid;
    logic [WB_PORTS*IDX_W-1:0] wb_id;
    logic [WB_PORTS*XLEN-1:0]  wb_val;
    logic                      st_valid;
    logic [IDX_W-1:0]          st_id, q1_id, q2_id;
    logic [XLEN-1:0]           st_addr, st_data;
    logic                      q1_ready, q2_ready;
    logic [XLEN-1:0]           q1_val, q2_val;
    logic                      rob_full, rob_empty;
    logic [IDX_W:0]            rob_count;
    logic [IDX_W-1:0]          rob_head_id, rob_tail_id;
    logic                      rf0_en, rf1_en;
    logic [4:0]                rf0_rd, rf1_rd;
    logic [XLEN-1:0]           rf0_val, rf1_val;
    logic                      rob_store_en;
    logic [LSB_W-1:0]          rob_store_lsb_id;
    logic                      rob_flush;
    logic [XLEN-1:0]           rob_correct_pc;
    logic                      rob_bp_en, rob_bp_jump, rob_bp_correct;
    logic [XLEN-1:0]           rob_bp_inst_addr;

    always #5 clk = ~clk;

    rob_multi_commit #(.IDX_W(IDX_W), .XLEN(XLEN), .LSB_W(LSB_W), .WB_PORTS(WB_PORTS)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
        .alloc_val(alloc_val), .alloc_ready(alloc_ready), .alloc_pred(alloc_pred),
        .alloc_addr(alloc_addr), .alloc_inst_addr(alloc_inst_addr), .alloc_c(alloc_c),
        .alloc_lsb_id(alloc_lsb_id),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .st_valid(st_valid), .st_id(st_id), .st_addr(st_addr), .st_data(st_data),
        .q1_id(q1_id), .q2_id(q2_id),
        .q1_ready(q1_ready), .q1_val(q1_val), .q2_ready(q2_ready), .q2_val(q2_val),
        .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count),
        .rob_head_id(rob_head_id), .rob_tail_id(rob_tail_id),
        .rf0_en(rf0_en), .rf0_rd(rf0_rd), .rf0_val(rf0_val),
        .rf1_en(rf1_en), .rf1_rd(rf1_rd), .rf1_val(rf1_val),
        .rob_store_en(rob_store_en), .rob_store_lsb_id(rob_store_lsb_id),
        .rob_flush(rob_flush), .rob_correct_pc(rob_correct_pc),
        .rob_bp_en(rob_bp_en), .rob_bp_inst_addr(rob_bp_inst_addr),
        .rob_bp_jump(rob_bp_jump), .rob_bp_correct(rob_bp_correct)
    );

    // Model: live entries oldest-first, kinds 0=REG 1=STORE 2=BRANCH 3=JALR.
    typedef struct {
        int          id;
        int          kind;
        int          rd;
        logic [31:0] val;
        bit          ready;
        bit          pred;
        logic [31:0] addr;
        logic [31:0] pc;
        bit          c;
        int          lsb;
    } ent_t;

    ent_t        mq[$];
    int          m_head = 0;
    bit          e_rf0_en, e_rf1_en, e_st_en, e_flush, e_bp_en, e_bp_jump, e_bp_corr;
    int          e_rf0_rd, e_rf1_rd, e_lsb;
    logic [31:0] e_rf0_val, e_rf1_val, e_cpc, e_bp_pc;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int find(input int id);
        foreach (mq[i]) if (mq[i].id == id) return i;
        return -1;
    endfunction

    task automatic set_idle();
        rst = 0; rdy = 1; flush = 0;
        alloc_valid = 0; alloc_kind = 0; alloc_rd = 0; alloc_val = 0; alloc_ready = 0;
        alloc_pred = 0; alloc_addr = 0; alloc_inst_addr = 0; alloc_c = 0; alloc_lsb_id = 0;
        wb_valid = 0; wb_id = 0; wb_val = 0;
        st_valid = 0; st_id = 0; st_addr = 0; st_data = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        ent_t h0, h1;
        bit   c0, c1, taken;
        int   n, j;
        if (rst) begin
            mq.delete(); m_head = 0;
            e_rf0_en = 0; e_rf1_en = 0; e_st_en = 0; e_flush = 0; e_bp_en = 0;
            e_cpc = 0;
            return;
        end
        if (!rdy) return;
        e_rf0_en = 0; e_rf1_en = 0; e_st_en = 0; e_flush = 0; e_bp_en = 0;
        if (flush) begin
            mq.delete();
            return;
        end
        n  = mq.size();
        c0 = (n > 0) && mq[0].ready;
        c1 = DUAL && c0 && (n > 1) && mq[1].ready && mq[0].kind == 0 && mq[1].kind == 0;
        if (c0) h0 = mq[0];
        if (c1) h1 = mq[1];
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[k]) begin
                j = find(int'(wb_id[k*IDX_W +: IDX_W]));
                if (j >= 0) begin
                    mq[j].ready = 1;
                    if (mq[j].kind == 3) mq[j].addr = wb_val[k*XLEN +: XLEN];
                    else                 mq[j].val  = wb_val[k*XLEN +: XLEN];
                end
            end
        end
        j = find(int'(st_id));
        if (st_valid && j >= 0 && mq[j].kind == 1) begin
            mq[j].addr = st_addr; mq[j].val = st_data; mq[j].ready = 1;
        end
        if (alloc_valid && n < DEPTH) begin
            ent_t e;
            e.id = (m_head + n) % DEPTH; e.kind = int'(alloc_kind); e.rd = int'(alloc_rd);
            e.val = alloc_val; e.ready = alloc_ready; e.pred = alloc_pred; e.addr = alloc_addr;
            e.pc = alloc_inst_addr; e.c = alloc_c; e.lsb = int'(alloc_lsb_id);
            mq.push_back(e);
        end
        if (c0) begin
            case (h0.kind)
                0: begin e_rf0_en = 1; e_rf0_rd = h0.rd; e_rf0_val = h0.val; end
                1: begin e_st_en = 1; e_lsb = h0.lsb; end
                2: begin
                    taken = h0.val[0];
                    e_bp_en = 1; e_bp_pc = h0.pc; e_bp_jump = taken; e_bp_corr = (h0.pred == taken);
                    if (h0.pred != taken) begin
                        e_flush = 1;
                        e_cpc = taken ? h0.addr : h0.pc + (h0.c ? 32'd2 : 32'd4);
                    end
                end
                default: begin
                    e_rf0_en = 1; e_rf0_rd = h0.rd; e_rf0_val = h0.val;
                    e_flush = 1; e_cpc = h0.addr;
                end
            endcase
            void'(mq.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (c1) begin
            e_rf1_en = 1; e_rf1_rd = h1.rd; e_rf1_val = h1.val;
            void'(mq.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
    endtask

    task automatic compare();
        int j;
        chk("count", rob_count, mq.size());
        chk("empty", rob_empty, mq.size() == 0);
        chk("full", rob_full, mq.size() == DEPTH);
        chk("head", rob_head_id, m_head);
        chk("tail", rob_tail_id, (m_head + mq.size()) % DEPTH);
        chk("rf0_en", rf0_en, e_rf0_en);
        if (e_rf0_en) begin chk("rf0_rd", rf0_rd, e_rf0_rd); chk("rf0_val", rf0_val, e_rf0_val); end
        chk("rf1_en", rf1_en, e_rf1_en);
        if (e_rf1_en) begin chk("rf1_rd", rf1_rd, e_rf1_rd); chk("rf1_val", rf1_val, e_rf1_val); end
        chk("store_en", rob_store_en, e_st_en);
        if (e_st_en) chk("store_lsb", rob_store_lsb_id, e_lsb);
        chk("rob_flush", rob_flush, e_flush);
        if (e_flush) chk("correct_pc", rob_correct_pc, e_cpc);
        chk("bp_en", rob_bp_en, e_bp_en);
        if (e_bp_en) begin
            chk("bp_pc", rob_bp_inst_addr, e_bp_pc);
            chk("bp_jump", rob_bp_jump, e_bp_jump);
            chk("bp_correct", rob_bp_correct, e_bp_corr);
        end
        q1_id = IDX_W'($urandom); q2_id = IDX_W'($urandom);
        #1;
        j = find(int'(q1_id));
        if (j >= 0) begin chk("q1_ready", q1_ready, mq[j].ready); chk("q1_val", q1_val, mq[j].val); end
        j = find(int'(q2_id));
        if (j >= 0) begin chk("q2_ready", q2_ready, mq[j].ready); chk("q2_val", q2_val, mq[j].val); end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare();
        set_idle();
    endtask

    task automatic rand_inputs();
        int j;
        logic [IDX_W-1:0] id;
        bit v;
        rdy         = ($urandom_range(0, 9) != 0);
        flush       = e_flush || ($urandom_range(0, 59) == 0);
        alloc_valid = ($urandom_range(0, 2) != 0);
        alloc_kind  = 2'($urandom_range(0, 3));
        alloc_rd    = 5'($urandom);
        alloc_val   = $urandom;
        alloc_ready = (alloc_kind == 0) && ($urandom_range(0, 3) == 0);
        alloc_pred  = 1'($urandom);
        alloc_addr  = $urandom;
        alloc_inst_addr = $urandom;
        alloc_c     = 1'($urandom);
        alloc_lsb_id = LSB_W'($urandom);
        for (int k = 0; k < WB_PORTS; k++) begin
            v  = ($urandom_range(0, 1) == 1);
            id = IDX_W'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                id = IDX_W'(mq[$urandom_range(0, mq.size() - 1)].id);
            j = find(int'(id));
            if (j >= 0 && mq[j].kind == 1) v = 0;
            wb_valid[k] = v;
            wb_id[k*IDX_W +: IDX_W] = id;
            wb_val[k*XLEN +: XLEN]  = $urandom;
        end
        st_id = IDX_W'($urandom); st_addr = $urandom; st_data = $urandom;
        if (mq.size() > 0) begin
            j = $urandom_range(0, mq.size() - 1);
            if (mq[j].kind == 1 && $urandom_range(0, 1) == 1) begin
                st_valid = 1; st_id = IDX_W'(mq[j].id);
            end
        end
    endtask

    initial begin
        set_idle();
        q1_id = 0; q2_id = 0;
        rst = 1; cyc();
        rst = 1; cyc();
        chk("rst_count", rob_count, 0);
        chk("rst_empty", rob_empty, 1);
        chk("rst_full", rob_full, 0);
        chk("rst_cpc", rob_correct_pc, 0);
        chk("rst_flush", rob_flush, 0);

        // Fill with unresolved REG entries, then try one more.
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1; alloc_kind = 0; alloc_rd = 5'(i + 1); alloc_val = 32'(i);
            cyc();
        end
        chk("fill_full", rob_full, 1);
        chk("fill_count", rob_count, 8);
        chk("fill_tail", rob_tail_id, 0);
        alloc_valid = 1; alloc_rd = 5'd20; cyc();
        chk("ovf_count", rob_count, 8);

        // Resolve ids 0 and 1 on two channels.
        wb_valid = 2'b11; wb_id = {3'd1, 3'd0}; wb_val = {32'd7, 32'd5}; cyc();
        cyc();
        chk("dc_rf0_en", rf0_en, 1);
        chk("dc_rf0_rd", rf0_rd, 1);
        chk("dc_rf0_val", rf0_val, 5);
`ifdef ROB_DUAL_COMMIT_EN
        chk("dc_rf1_en", rf1_en, 1);
        chk("dc_rf1_rd", rf1_rd, 2);
        chk("dc_rf1_val", rf1_val, 7);
        chk("dc_count", rob_count, 6);
`else
        chk("sc_rf1_en", rf1_en, 0);
        chk("sc_count1", rob_count, 7);
        cyc();
        chk("sc_rf0_rd", rf0_rd, 2);
        chk("sc_rf0_val", rf0_val, 7);
        chk("sc_count2", rob_count, 6);
`endif
        flush = 1; cyc();
        chk("fl_count", rob_count, 0);
        chk("fl_tail", rob_tail_id, 2);

        // Mispredicted not-taken compressed branch.
        alloc_valid = 1; alloc_kind = 2; alloc_pred = 1; alloc_inst_addr = 32'h100;
        alloc_c = 1; alloc_addr = 32'h500; cyc();
        wb_valid = 2'b01; wb_id = {3'd0, 3'd2}; wb_val = 64'd0; cyc();
        cyc();
        chk("br_flush", rob_flush, 1);
        chk("br_cpc", rob_correct_pc, 32'h102);
        chk("br_bp_en", rob_bp_en, 1);
        chk("br_bp_correct", rob_bp_correct, 0);
        flush = 1; cyc();
        chk("br_fl_count", rob_count, 0);
        chk("br_fl_tail", rob_tail_id, 3);

        // JALR: link value from allocation, target from writeback.
        alloc_valid = 1; alloc_kind = 3; alloc_rd = 5'd1; alloc_val = 32'h304;
        alloc_inst_addr = 32'h300; cyc();
        wb_valid = 2'b01; wb_id = {3'd0, 3'd3}; wb_val = {32'd0, 32'h2000}; cyc();
        cyc();
        chk("jalr_rf0_en", rf0_en, 1);
        chk("jalr_rf0_val", rf0_val, 32'h304);
        chk("jalr_flush", rob_flush, 1);
        chk("jalr_cpc", rob_correct_pc, 32'h2000);
        flush = 1; cyc();

        // STORE then REG: store releases alone, REG follows next cycle.
        alloc_valid = 1; alloc_kind = 1; alloc_lsb_id = 3'd5; cyc();
        alloc_valid = 1; alloc_kind = 0; alloc_rd = 5'd9; alloc_val = 32'h55; alloc_ready = 1;
        st_valid = 1; st_id = 3'd4; st_addr = 32'h40; st_data = 32'h99; cyc();
        cyc();
        chk("st_en", rob_store_en, 1);
        chk("st_lsb", rob_store_lsb_id, 5);
        chk("st_rf0_en", rf0_en, 0);
        cyc();
        chk("st_reg_en", rf0_en, 1);
        chk("st_reg_rd", rf0_rd, 9);
        chk("st_reg_val", rf0_val, 32'h55);

        // Writeback to a dead id leaves the buffer empty.
        wb_valid = 2'b01; wb_id = {3'd0, 3'd0}; wb_val = {32'd0, 32'hdead}; cyc();
        chk("dead_count", rob_count, 0);
        chk("dead_head", rob_head_id, 6);

        // Streaming allocate/commit across the 7->0 wrap.
        for (int i = 0; i < 20; i++) begin
            alloc_valid = 1; alloc_kind = 0; alloc_rd = 5'(i); alloc_val = 32'(i * 3);
            alloc_ready = 1;
            cyc();
        end
        chk("wrap_tail", rob_tail_id, 2);
        chk("wrap_head", rob_head_id, 1);
        chk("wrap_count", rob_count, 1);

        // Random traffic with a mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            if (n == 1500) begin rst = 1; rdy = 0; end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
